// File: rtl/spix_pkg.sv
// Shared encodings for the SPI burst slave: instruction codes, FSM states and a
// constant clog2 helper used to size address and bit-count fields.
package spix_pkg;

   typedef enum logic [1:0] {
      InsNop      = 2'b00,
      InsRead     = 2'b01,
      InsWrite    = 2'b10,
      InsReadback = 2'b11
   } ins_e;

   typedef enum logic [2:0] {
      StCmd,
      StAddr,
      StWdata,
      StRdata,
      StIgnore
   } state_e;

   localparam int unsigned CmdBits = 2;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((64'd1 << res) < 64'(value)) res++;
      return res;
   endfunction

endpackage

// File: rtl/spix_shreg.sv
// Word-wide shift register: parallel load has priority over a left shift that
// takes in one serial bit; the MSB is the serial output.
module spix_shreg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             msb
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], sin};
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/spix_burst.sv
// SPI slave with burst register writes, input-word reads and register readback.
// CLK doubles as the serial clock; DOUT is gated low whenever DOE is low.
module spix_burst
   import spix_pkg::*;
#(
   parameter int unsigned REGISTERS = 8,
   parameter int unsigned INPUTS    = 6,
   parameter int unsigned SWORD     = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       CEB,
   input  logic                       DATA,
   output logic                       DOUT,
   output logic                       DOE,
   output logic [REGISTERS*SWORD-1:0] R,
   output logic [REGISTERS-1:0]       WSTB,
   input  logic [INPUTS*SWORD-1:0]    RD,
   output logic [INPUTS-1:0]          RSTB
);

   localparam int unsigned MaxWords = (REGISTERS > INPUTS) ? REGISTERS : INPUTS;
   localparam int unsigned AW = (clog2(MaxWords) > 1) ? clog2(MaxWords) : 1;
   localparam int unsigned CW = clog2(SWORD + AW + CmdBits);

   state_e               state_q, state_d;
   ins_e                 instr_q, instr_d;
   logic [AW-1:0]        addr_q, addr_d, addr_in, fetch_addr;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 armed_q, armed_d;
   logic                 doe_q, doe_d;
   logic [SWORD-1:0]     reg_q [REGISTERS];
   logic [SWORD-1:0]     reg_d [REGISTERS];
   logic [SWORD-1:0]     rd_word [INPUTS];
   logic [REGISTERS-1:0] wstb_q, wstb_d;
   logic [INPUTS-1:0]    rstb_q, rstb_d;

   logic             rx_load, rx_shift, tx_load, tx_shift, fetch, tx_msb;
   logic [SWORD-1:0] rx_q, rx_word, tx_val, tx_q_unused;
   logic             rx_msb_unused, rx_top_unused;

   for (genvar i = 0; i < REGISTERS; i++) begin : g_r
      assign R[i*SWORD +: SWORD] = reg_q[i];
   end
   for (genvar i = 0; i < INPUTS; i++) begin : g_rd
      assign rd_word[i] = RD[i*SWORD +: SWORD];
   end

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input int unsigned lim);
      return (32'(a) == lim - 1) ? '0 : a + 1'b1;
   endfunction

   assign addr_in       = AW'({addr_q, DATA});
   assign rx_word       = {rx_q[SWORD-2:0], DATA};
   assign rx_top_unused = rx_q[SWORD-1];

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      armed_d    = armed_q;
      doe_d      = doe_q;
      reg_d      = reg_q;
      wstb_d     = '0;
      rstb_d     = '0;
      rx_load    = 1'b0;
      rx_shift   = 1'b0;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      tx_val     = '0;
      fetch      = 1'b0;
      fetch_addr = addr_q;
      if (CEB) begin
         state_d = StCmd;
         cnt_d   = '0;
         doe_d   = 1'b0;
         armed_d = 1'b1;
         rx_load = 1'b1;
         tx_load = 1'b1;
      end else if (armed_q) begin
         unique case (state_q)
            StCmd: begin
               instr_d = ins_e'({instr_q[0], DATA});
               if (cnt_q == CW'(CmdBits - 1)) begin
                  cnt_d   = '0;
                  state_d = StAddr;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StAddr: begin
               addr_d = addr_in;
               if (cnt_q == CW'(AW - 1)) begin
                  cnt_d = '0;
                  unique case (instr_q)
                     InsWrite: state_d = StWdata;
                     InsRead, InsReadback: begin
                        state_d    = StRdata;
                        fetch      = 1'b1;
                        fetch_addr = addr_in;
                        doe_d      = 1'b1;
                     end
                     InsNop: state_d = StIgnore;
                  endcase
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StWdata: begin
               rx_shift = 1'b1;
               if (cnt_q == CW'(SWORD - 1)) begin
                  cnt_d = '0;
                  if (32'(addr_q) < REGISTERS) begin
                     reg_d[addr_q]  = rx_word;
                     wstb_d[addr_q] = 1'b1;
                  end
                  addr_d = next_addr(addr_q, REGISTERS);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StRdata: begin
               if (cnt_q == CW'(SWORD - 1)) begin
                  cnt_d      = '0;
                  addr_d     = next_addr(addr_q, (instr_q == InsRead) ? INPUTS : REGISTERS);
                  fetch      = 1'b1;
                  fetch_addr = addr_d;
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  tx_shift = 1'b1;
               end
            end
            StIgnore: ;
            default: state_d = StCmd;
         endcase
      end
      // Readback samples reg_d so a write landing on the same edge is visible.
      if (fetch) begin
         tx_load = 1'b1;
         if (instr_q == InsRead) begin
            if (32'(fetch_addr) < INPUTS) begin
               tx_val             = rd_word[fetch_addr];
               rstb_d[fetch_addr] = 1'b1;
            end
         end else if (32'(fetch_addr) < REGISTERS) begin
            tx_val = reg_d[fetch_addr];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StCmd;
         instr_q <= InsNop;
         addr_q  <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         doe_q   <= 1'b0;
         wstb_q  <= '0;
         rstb_q  <= '0;
         for (int i = 0; i < REGISTERS; i++) reg_q[i] <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         doe_q   <= doe_d;
         wstb_q  <= wstb_d;
         rstb_q  <= rstb_d;
         for (int i = 0; i < REGISTERS; i++) reg_q[i] <= reg_d[i];
      end
   end

   spix_shreg #(.WIDTH(SWORD)) u_rx (
      .clk      (CLK),
      .rst      (RST),
      .load     (rx_load),
      .load_val ('0),
      .shift    (rx_shift),
      .sin      (DATA),
      .q        (rx_q),
      .msb      (rx_msb_unused)
   );

   spix_shreg #(.WIDTH(SWORD)) u_tx (
      .clk      (CLK),
      .rst      (RST),
      .load     (tx_load),
      .load_val (tx_val),
      .shift    (tx_shift),
      .sin      (1'b0),
      .q        (tx_q_unused),
      .msb      (tx_msb)
   );

   assign DOUT = doe_q & tx_msb;
   assign DOE  = doe_q;
   assign WSTB = wstb_q;
   assign RSTB = rstb_q;

endmodule

// File: doc/spix_burst.md
SPIX_BURST -- requirements
Module: spix_burst

Interface
REQ-001 SHALL have parameter REGISTERS, default 8, number of host-writable word registers.
REQ-002 SHALL have parameter INPUTS, default 6, number of read-only input words.
REQ-003 SHALL have parameter SWORD, default 8, bits per word.
REQ-004 SHALL derive localparam AW = max(1, clog2(max(REGISTERS,INPUTS))) as the address field width.
REQ-005 CLK  input  1  single clock, also the SPI serial clock; all state changes on rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 CEB  input  1  chip select, active low.
REQ-008 DATA  input  1  serial data in (MOSI), sampled on rising CLK, MSB first.
REQ-009 DOUT  output  1  serial data out (MISO), MSB first; 0 when DOE low.
REQ-010 DOE  output  1  DOUT valid/drive enable; replaces internal tri-state.
REQ-011 R  output  REGISTERS*SWORD  register file, word i at bits [(i+1)*SWORD-1 : i*SWORD].
REQ-012 WSTB  output  REGISTERS  one-cycle pulse per register written.
REQ-013 RD  input  INPUTS*SWORD  input words, same packing as R.
REQ-014 RSTB  output  INPUTS  one-cycle pulse when input word i is captured for transmission (pop strobe for FIFO sources).

Function
REQ-015 Frame = CEB low; header = 2 instruction bits then AW address bits, all MSB first.
REQ-016 Instruction encoding SHALL be 00 NOP, 01 READ inputs, 10 WRITE registers, 11 READBACK registers.
REQ-017 FSM states SHALL be CMD, ADDR, WDATA, RDATA, IGNORE; CMD->ADDR after 2 bits; ADDR->WDATA/RDATA (by instruction) or IGNORE (NOP) after AW bits.
REQ-018 Any edge with CEB high SHALL return the FSM to CMD, clear bit counters, discard partial words, and drop DOE.
REQ-019 WDATA: on the edge sampling the SWORD-th data bit, R[addr] SHALL load the full word (including that bit) and WSTB[addr] SHALL pulse in the following cycle.
REQ-020 Burst: after each completed word the address SHALL increment, wrapping REGISTERS-1 -> 0 (WRITE/READBACK) or INPUTS-1 -> 0 (READ); the frame continues until CEB rises.
REQ-021 Writes to addr >= REGISTERS SHALL be ignored (no R change, no WSTB); the address still increments.
REQ-022 RDATA: on the edge sampling the last address bit, and on every SWORD-th data edge thereafter, the output shifter SHALL load source[addr] (RD for READ, R for READBACK); it shifts left one bit on all other RDATA edges.
REQ-023 DOUT SHALL equal the shifter MSB and DOE SHALL be 1 from the cycle after the first load until CEB rises.
REQ-024 READ of addr >= INPUTS or READBACK of addr >= REGISTERS SHALL load all zeros, with no RSTB.
REQ-025 RSTB[addr] SHALL pulse in the cycle after each READ load of a valid address.
REQ-026 DATA bits received during RDATA or IGNORE SHALL be ignored.
REQ-027 A READBACK word SHALL reflect R as of the load edge, including a write completed on that same edge.

Reset
REQ-028 RST high SHALL set FSM=CMD, all R words=0, WSTB=0, RSTB=0, DOE=0, DOUT=0, shifters/counters=0, with priority over CEB and DATA.
REQ-029 RST asserted mid-frame SHALL abort the frame; the next frame SHALL begin only after CEB has been seen high at least once.

Structure
REQ-030 Package spix_pkg SHALL hold the instruction encodings, the FSM state encoding, and the clog2 function.
REQ-031 Sub-module spix_shreg (SWORD-wide shift register with parallel load, shift enable, serial in, MSB out) SHALL be instantiated once for receive and once for transmit.
REQ-032 Target size 120-400 RTL lines; no tri-state or latches.

Verification (REGISTERS=8, INPUTS=6, SWORD=8, AW=3)
REQ-033 Write: CEB low, bits 10,011,10100101 -> R[3]=0xA5 after 13th edge, WSTB=0x08 for one cycle, other R unchanged.
REQ-034 Burst wrap: 10,110 then 0x11,0x22,0x33 -> R[6]=0x11, R[7]=0x22, R[0]=0x33, three WSTB pulses.
REQ-035 Read: RD[2]=0x3C, bits 01,010 -> DOE=1, DOUT over next 8 cycles 0,0,1,1,1,1,0,0, RSTB=0x04 once; continuing yields RD[3].
REQ-036 Readback after REQ-033: 11,011 -> DOUT serialises 0xA5; READ of addr 7 -> 0x00, no RSTB.
REQ-037 Abort: CEB rises after 4 WDATA bits -> no R change, no WSTB; next frame 10,001,0xFF -> R[1]=0xFF.
REQ-038 Reset mid-burst: RST high during WDATA -> all R=0, DOE=0, FSM=CMD; a following frame with CEB high first decodes correctly.
